branch_pc_ctrl: RTL and testbench

- Sits directly downstream of the CON flip-flop logic in the Mini SRC datapath and consumes its branch-condition result.
- Owns the program counter register and sequences the conditional-branch execute steps T3–T5.
- When the condition is met, it loads PC with the branch target, PC + sign-extended C.
- Also handles fetch-time PC increment and register-indirect PC load (jr/jal).

---
 rtl/branch_pc_ctrl.sv | 112 +++++++++++
 tb/tb_branch_pc_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_ctrl.sv
// Program counter owner for the Mini SRC datapath: fetch increment, jr/jal load and the T3-T5 conditional branch sequence.
// Optional macro BRANCH_STATS_EN enables the saturating taken-branch counter on taken_count.
module branch_pc_ctrl #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            C_WIDTH    = 19,
    parameter logic [ADDR_WIDTH-1:0]  PC_RESET   = '0
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [1:0]            ir_cond,
    input  logic [C_WIDTH-1:0]    ir_c,
    input  logic [ADDR_WIDTH-1:0] bus_in,
    input  logic                  pc_ld,
    input  logic                  pc_inc,
    input  logic                  con_q,
    output logic                  con_en,
    output logic [1:0]            cond_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  busy,
    output logic                  done,
    output logic                  taken,
    output logic [15:0]           taken_count
);

    localparam int unsigned EXT_WIDTH = ADDR_WIDTH - C_WIDTH;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T3   = 3'd1,
        T4   = 3'd2,
        T5   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [C_WIDTH-1:0]    c_q;
    logic [ADDR_WIDTH-1:0] target_q;
    logic [ADDR_WIDTH-1:0] c_ext;

    assign c_ext = {{EXT_WIDTH{c_q[C_WIDTH-1]}}, c_q};

    // Next-state logic; every non-IDLE state lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = T3;
            T3:      state_d = T4;
            T4:      state_d = T5;
            T5:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus registered strobes decoded from the upcoming state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            con_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            taken    <= 1'b0;
            cond_out <= 2'b00;
            c_q      <= '0;
            target_q <= '0;
            pc_out   <= PC_RESET;
        end else begin
            state_q <= state_d;
            con_en  <= (state_d == T3);
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);

            // PC ops only in IDLE; a coincident start sees the updated PC at T4.
            if (state_q == IDLE) begin
                if (pc_ld) begin
                    pc_out <= bus_in;
                end else if (pc_inc) begin
                    pc_out <= pc_out + ADDR_WIDTH'(1);
                end
                if (start) begin
                    cond_out <= ir_cond;
                    c_q      <= ir_c;
                end
            end

            if (state_q == T4) begin
                taken    <= con_q;
                target_q <= pc_out + c_ext;
            end

            if ((state_q == T5) && taken) begin
                pc_out <= target_q;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating count of taken branches, cleared only by clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            taken_count <= 16'h0000;
        end else if ((state_q == T5) && taken && (taken_count != 16'hFFFF)) begin
            taken_count <= taken_count + 16'd1;
        end
    end
`else
    assign taken_count = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Randomized self-checking bench for branch_pc_ctrl against a transaction-level PC/branch model.
module tb_branch_pc_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 19;
    localparam logic [AW-1:0] PC_RST = 32'h0;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [1:0]    ir_cond;
    logic [CW-1:0] ir_c;
    logic [AW-1:0] bus_in;
    logic          pc_ld;
    logic          pc_inc;
    logic          con_q;
    logic          con_en;
    logic [1:0]    cond_out;
    logic [AW-1:0] pc_out;
    logic          busy;
    logic          done;
    logic          taken;
    logic [15:0]   taken_count;

    int applied = 0;
    int miscompares = 0;

    logic [AW-1:0] m_pc;
    logic          m_taken;
    logic [15:0]   m_count;

    branch_pc_ctrl #(.ADDR_WIDTH(AW), .C_WIDTH(CW), .PC_RESET(PC_RST)) dut (
        .clk(clk), .clr(clr), .start(start), .ir_cond(ir_cond), .ir_c(ir_c),
        .bus_in(bus_in), .pc_ld(pc_ld), .pc_inc(pc_inc), .con_q(con_q),
        .con_en(con_en), .cond_out(cond_out), .pc_out(pc_out), .busy(busy),
        .done(done), .taken(taken), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] sext(input logic [CW-1:0] c);
        int v;
        v = int'(c);
        if (v >= (1 << (CW - 1))) v = v - (1 << CW);
        return AW'(v);
    endfunction

    function automatic logic [15:0] exp_count();
`ifdef BRANCH_STATS_EN
        return m_count;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic quiet_inputs();
        start = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0;
        ir_cond = 2'b00; ir_c = '0; bus_in = '0; con_q = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #2;
        m_pc = PC_RST; m_taken = 1'b0; m_count = 16'h0;
        tick();
        clr = 1'b0;
        tick();
    endtask

    // One IDLE cycle with optional PC op, no start.
    task automatic pc_op(input logic ld, input logic inc, input logic [AW-1:0] bus);
        pc_ld = ld; pc_inc = inc; bus_in = bus; con_q = 1'($urandom);
        tick();
        if (ld) m_pc = bus; else if (inc) m_pc = m_pc + 32'd1;
        pc_ld = 1'b0; pc_inc = 1'b0;
        applied++; if (pc_out !== m_pc) begin miscompares++; $display("FAIL idle_pc got %h exp %h", pc_out, m_pc); end
        applied++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    // Full branch: start (with optional PC op) then T3,T4,T5,DONE and back to IDLE.
    task automatic run_branch(input logic ld, input logic inc, input logic [AW-1:0] bus,
                              input logic [1:0] cond, input logic [CW-1:0] c,
                              input logic cq, input logic meddle);
        logic [AW-1:0] pc_before;
        start = 1'b1; pc_ld = ld; pc_inc = inc; bus_in = bus;
        ir_cond = cond; ir_c = c; con_q = 1'($urandom);
        if (ld) m_pc = bus; else if (inc) m_pc = m_pc + 32'd1;
        pc_before = m_pc;
        tick();  // now in T3
        start = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0;
        applied++; if (con_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL t3_strobes got en=%b busy=%b done=%b exp 1 1 0", con_en, busy, done); end
        applied++; if (cond_out !== cond) begin miscompares++; $display("FAIL t3_cond got %b exp %b", cond_out, cond); end
        applied++; if (pc_out !== pc_before) begin miscompares++; $display("FAIL t3_pc got %h exp %h", pc_out, pc_before); end
        if (meddle) begin
            start = 1'($urandom); pc_ld = 1'($urandom); pc_inc = 1'($urandom);
            bus_in = $urandom; ir_cond = 2'($urandom); ir_c = CW'($urandom);
        end
        con_q = cq;
        tick();  // now in T4; con_q sampled on the edge leaving it
        applied++; if (con_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL t4_strobes got en=%b busy=%b done=%b exp 0 1 0", con_en, busy, done); end
        applied++; if (pc_out !== pc_before || taken !== m_taken) begin miscompares++; $display("FAIL t4_hold got pc=%h tk=%b exp pc=%h tk=%b", pc_out, taken, pc_before, m_taken); end
        tick();  // now in T5
        con_q = ~cq;
        m_taken = cq;
        applied++; if (taken !== m_taken) begin miscompares++; $display("FAIL t5_taken got %b exp %b", taken, m_taken); end
        applied++; if (pc_out !== pc_before || done !== 1'b0 || con_en !== 1'b0) begin miscompares++; $display("FAIL t5_state got pc=%h done=%b en=%b exp pc=%h 0 0", pc_out, done, con_en, pc_before); end
        tick();  // now in DONE
        if (cq) begin
            m_pc = pc_before + sext(c);
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        end
        applied++; if (pc_out !== m_pc) begin miscompares++; $display("FAIL done_pc got %h exp %h", pc_out, m_pc); end
        applied++; if (done !== 1'b1 || busy !== 1'b1 || con_en !== 1'b0) begin miscompares++; $display("FAIL done_strobes got done=%b busy=%b en=%b exp 1 1 0", done, busy, con_en); end
        applied++; if (cond_out !== cond) begin miscompares++; $display("FAIL done_cond got %b exp %b", cond_out, cond); end
        applied++; if (taken_count !== exp_count()) begin miscompares++; $display("FAIL taken_count got %h exp %h", taken_count, exp_count()); end
        tick();  // back in IDLE
        quiet_inputs();
        applied++; if (done !== 1'b0 || busy !== 1'b0 || pc_out !== m_pc || taken !== m_taken) begin miscompares++; $display("FAIL idle_after got done=%b busy=%b pc=%h tk=%b exp 0 0 %h %b", done, busy, pc_out, taken, m_pc, m_taken); end
    endtask

    task automatic test_reset();
        quiet_inputs();
        clr = 1'b1;
        #3;
        applied++; if (pc_out !== PC_RST || busy !== 1'b0 || done !== 1'b0 || con_en !== 1'b0) begin miscompares++; $display("FAIL reset_out got pc=%h busy=%b done=%b en=%b", pc_out, busy, done, con_en); end
        applied++; if (taken !== 1'b0 || cond_out !== 2'b00 || taken_count !== 16'h0) begin miscompares++; $display("FAIL reset_misc got tk=%b cond=%b cnt=%h exp 0 0 0", taken, cond_out, taken_count); end
        do_reset();
    endtask

    task automatic test_wrap_priority();
        pc_op(1'b1, 1'b0, 32'hFFFF_FFFF);
        pc_op(1'b0, 1'b1, 32'h0);
        applied++; if (pc_out !== 32'h0) begin miscompares++; $display("FAIL wrap got %h exp 00000000", pc_out); end
        pc_op(1'b1, 1'b1, 32'h40);
        applied++; if (pc_out !== 32'h40) begin miscompares++; $display("FAIL ld_prio got %h exp 00000040", pc_out); end
    endtask

    task automatic test_taken_backward();
        pc_op(1'b1, 1'b0, 32'h20);
        run_branch(1'b0, 1'b0, 32'h0, 2'b10, 19'h7FFFC, 1'b1, 1'b0);
        applied++; if (pc_out !== 32'h1C || taken !== 1'b1) begin miscompares++; $display("FAIL backward got pc=%h tk=%b exp 0000001c 1", pc_out, taken); end
    endtask

    task automatic test_not_taken();
        pc_op(1'b1, 1'b0, 32'h20);
        run_branch(1'b0, 1'b0, 32'h0, 2'b01, 19'h00010, 1'b0, 1'b0);
        applied++; if (pc_out !== 32'h20 || taken !== 1'b0) begin miscompares++; $display("FAIL not_taken got pc=%h tk=%b exp 00000020 0", pc_out, taken); end
    endtask

    task automatic test_busy_interlock();
        pc_op(1'b1, 1'b0, 32'h300);
        run_branch(1'b0, 1'b0, 32'h0, 2'b11, 19'h00100, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            applied++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL no_requeue got done=%b busy=%b exp 0 0", done, busy); end
        end
        pc_op(1'b1, 1'b0, 32'h10);
        run_branch(1'b0, 1'b1, 32'h0, 2'b00, 19'd2, 1'b1, 1'b0);
        applied++; if (pc_out !== 32'h13) begin miscompares++; $display("FAIL start_inc got %h exp 00000013", pc_out); end
    endtask

    task automatic test_reset_mid();
        pc_op(1'b1, 1'b0, 32'h100);
        start = 1'b1; ir_c = 19'h00040; con_q = 1'b1;
        tick();  // T3
        start = 1'b0;
        tick();  // T4
        #2;
        clr = 1'b1;
        #1;
        m_pc = PC_RST; m_taken = 1'b0; m_count = 16'h0;
        applied++; if (pc_out !== PC_RST || busy !== 1'b0 || con_en !== 1'b0) begin miscompares++; $display("FAIL mid_clr got pc=%h busy=%b en=%b", pc_out, busy, con_en); end
        tick();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            applied++; if (done !== 1'b0 || busy !== 1'b0 || pc_out !== PC_RST || taken !== 1'b0) begin miscompares++; $display("FAIL mid_after got done=%b busy=%b pc=%h tk=%b", done, busy, pc_out, taken); end
        end
        quiet_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1) pc_op(1'($urandom), 1'($urandom), $urandom);
            run_branch(1'($urandom), 1'($urandom), $urandom, 2'($urandom), CW'($urandom),
                       1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_branch(1'b0, 1'b1, 32'h0, 2'b10, CW'($urandom), (i % 2 == 0), 1'b0);
        end
`ifdef BRANCH_STATS_EN
        applied++; if (taken_count !== 16'd3) begin miscompares++; $display("FAIL stats_total got %0d exp 3", taken_count); end
`else
        applied++; if (taken_count !== 16'd0) begin miscompares++; $display("FAIL stats_total got %0d exp 0", taken_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_wrap_priority();
        test_taken_backward();
        test_not_taken();
        test_busy_interlock();
        test_reset_mid();
        test_random();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
